// File: rtl/finder_pattern_scan_if.sv
// Handshake and frame-buffer port bundle of the finder-pattern scanner.
// The slave side is the scanner itself; the master side is the controller and frame buffer.
interface finder_pattern_scan_if;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned VEC_W  = 480;

    logic              start_scan;
    logic              pixel_reading;
    logic [ADDR_W-1:0] address_reading;
    logic [VEC_W-1:0]  horz_patterns;
    logic [VEC_W-1:0]  vert_patterns;
    logic              busy;
    logic              scan_done;

    modport master (
        output start_scan,
        output pixel_reading,
        input  address_reading,
        input  horz_patterns,
        input  vert_patterns,
        input  busy,
        input  scan_done
    );

    modport slave (
        input  start_scan,
        input  pixel_reading,
        output address_reading,
        output horz_patterns,
        output vert_patterns,
        output busy,
        output scan_done
    );
endinterface

// File: rtl/finder_pattern_scan.sv
// Row-major then column-major scan of the binarized frame, run-length encoding each
// line and flagging centres of 1:1:3:1:1 black/white run groups.
module finder_pattern_scan #(
    parameter int unsigned WIDTH        = 480,
    parameter int unsigned HEIGHT       = 480,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    finder_pattern_scan_if.slave bus
);
    localparam int unsigned CW    = 9;
    localparam int unsigned LW    = 9;
    localparam int unsigned TW    = 12;
    localparam int unsigned PW    = 16;
    localparam int unsigned AW    = 20;
    localparam int unsigned VW    = 480;
    localparam int unsigned HD    = 5;
    localparam int unsigned NW    = 3;
    localparam int unsigned DRAIN = READ_LATENCY + 1;
    localparam int unsigned DW    = $clog2(DRAIN + 1);

    localparam logic [CW-1:0] X_LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] Y_LAST    = CW'(HEIGHT - 1);
    localparam logic [DW-1:0] DRAIN_END = DW'(DRAIN - 1);
    localparam logic [NW-1:0] HIST_FULL = NW'(HD);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ROW_SCAN  = 3'd1;
    localparam logic [2:0] S_ROW_DRAIN = 3'd2;
    localparam logic [2:0] S_COL_SCAN  = 3'd3;
    localparam logic [2:0] S_COL_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    typedef struct packed {
        logic [LW-1:0] len;
        logic [CW-1:0] start;
        logic          colour;
    } run_t;

    typedef struct packed {
        logic          valid;
        logic          line_end;
        logic          col_pass;
        logic [CW-1:0] coord;
    } tap_t;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [VW-1:0] horz_q, horz_d, vert_q, vert_d;
    run_t          cur_q, cur_d;
    run_t          hist_q [HD];
    run_t          hist_d [HD];
    logic [NW-1:0] cnt_q, cnt_d;
    tap_t          tap_q [READ_LATENCY];
    tap_t          tap_in, tap;

    // Side runs must lie in [T/14, 3T/14], the core in [2T/7, 4T/7]
    function automatic logic ratio_ok(input logic [LW-1:0] l0, l1, l2, l3, l4);
        logic [TW-1:0] t;
        logic [PW-1:0] tt, k0, k1, k2, k3, k4;
        t  = TW'(l0) + TW'(l1) + TW'(l2) + TW'(l3) + TW'(l4);
        tt = PW'(t);
        k0 = PW'(14) * PW'(l0);
        k1 = PW'(14) * PW'(l1);
        k3 = PW'(14) * PW'(l3);
        k4 = PW'(14) * PW'(l4);
        k2 = PW'(7) * PW'(l2);
        return (t >= TW'(7))
            && (k0 >= tt) && (k0 <= PW'(3) * tt)
            && (k1 >= tt) && (k1 <= PW'(3) * tt)
            && (k3 >= tt) && (k3 <= PW'(3) * tt)
            && (k4 >= tt) && (k4 <= PW'(3) * tt)
            && (k2 >= PW'(2) * tt) && (k2 <= PW'(4) * tt);
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            horz_q  <= '0;
            vert_q  <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < HD; i++) hist_q[i] <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            horz_q  <= horz_d;
            vert_q  <= vert_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < HD; i++) hist_q[i] <= hist_d[i];
            tap_q[0] <= tap_in;
            for (int i = 1; i < READ_LATENCY; i++) tap_q[i] <= tap_q[i-1];
        end
    end

    // Sequencer: scan counters, drain timing and the tap that follows each fetch
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        drain_d = drain_q;
        tap_in  = '0;
        case (state_q)
            S_IDLE: if (bus.start_scan) state_d = S_ROW_SCAN;
            S_ROW_SCAN: begin
                tap_in.valid    = 1'b1;
                tap_in.line_end = (x_q == X_LAST);
                tap_in.coord    = x_q;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        state_d = S_ROW_DRAIN;
                    end else begin
                        y_d = y_q + CW'(1);
                    end
                end else begin
                    x_d = x_q + CW'(1);
                end
            end
            S_ROW_DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DRAIN_END) begin
                    drain_d = '0;
                    state_d = S_COL_SCAN;
                end
            end
            S_COL_SCAN: begin
                tap_in.valid    = 1'b1;
                tap_in.line_end = (y_q == Y_LAST);
                tap_in.col_pass = 1'b1;
                tap_in.coord    = y_q;
                if (y_q == Y_LAST) begin
                    y_d = '0;
                    if (x_q == X_LAST) begin
                        x_d     = '0;
                        state_d = S_COL_DRAIN;
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end else begin
                    y_d = y_q + CW'(1);
                end
            end
            S_COL_DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DRAIN_END) begin
                    drain_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_ROW_SCAN) || (state_d == S_ROW_DRAIN) ||
                 (state_d == S_COL_SCAN) || (state_d == S_COL_DRAIN);
        done_d = (state_d == S_DONE);
    end

    assign tap = tap_q[READ_LATENCY-1];

    // Run-length encoder and ratio test on the pixel returning from the frame buffer
    logic          pix, push_a, use_b, trig, match;
    run_t          run_a, run_b;
    run_t          h1 [HD];
    run_t          h2 [HD];
    logic [NW-1:0] c1, c2, wcnt;
    logic [LW-1:0] wl [HD];
    run_t          core;
    logic [CW-1:0] centre;

    assign pix = bus.pixel_reading;

    always_comb begin
        cur_d  = cur_q;
        cnt_d  = cnt_q;
        horz_d = horz_q;
        vert_d = vert_q;
        push_a = 1'b0;
        run_a  = cur_q;
        run_b  = cur_q;
        for (int i = 0; i < HD; i++) hist_d[i] = hist_q[i];

        if (state_q == S_IDLE && bus.start_scan) begin
            horz_d = '0;
            vert_d = '0;
        end

        if (cur_q.len == '0 || cur_q.colour != pix) begin
            push_a       = (cur_q.len != '0);
            run_b.len    = LW'(1);
            run_b.start  = tap.coord;
            run_b.colour = pix;
        end else begin
            run_b.len = cur_q.len + LW'(1);
        end
        push_a = push_a && tap.valid;

        // h1: history after a colour-change push; h2: after the line-end push
        for (int i = 0; i < HD; i++) h1[i] = hist_q[i];
        c1 = cnt_q;
        if (push_a) begin
            h1[0] = run_a;
            for (int i = 1; i < HD; i++) h1[i] = hist_q[i-1];
            c1 = (cnt_q == HIST_FULL) ? cnt_q : cnt_q + NW'(1);
        end
        for (int i = 0; i < HD; i++) h2[i] = h1[i];
        c2 = c1;
        if (tap.line_end) begin
            h2[0] = run_b;
            for (int i = 1; i < HD; i++) h2[i] = h1[i-1];
            c2 = (c1 == HIST_FULL) ? c1 : c1 + NW'(1);
        end

        use_b = tap.valid && tap.line_end && !run_b.colour;
        trig  = use_b || (push_a && !run_a.colour);
        wcnt  = use_b ? c2 : c1;
        for (int i = 0; i < HD; i++) wl[i] = use_b ? h2[i].len : h1[i].len;
        core   = use_b ? h2[2] : h1[2];
        centre = core.start + CW'(core.len >> 1);
        match  = trig && (wcnt == HIST_FULL) && !core.colour &&
                 ratio_ok(wl[4], wl[3], wl[2], wl[1], wl[0]);

        if (match && (32'(centre) < VW)) begin
            if (tap.col_pass) vert_d[centre] = 1'b1;
            else              horz_d[centre] = 1'b1;
        end

        if (tap.valid) begin
            if (tap.line_end) begin
                cur_d = '0;
                cnt_d = '0;
                for (int i = 0; i < HD; i++) hist_d[i] = '0;
            end else begin
                cur_d = run_b;
                cnt_d = c2;
                for (int i = 0; i < HD; i++) hist_d[i] = h2[i];
            end
        end
    end

    assign bus.address_reading = AW'(x_q) + AW'(y_q) * AW'(WIDTH);
    assign bus.horz_patterns   = horz_q;
    assign bus.vert_patterns   = vert_q;
    assign bus.busy            = busy_q;
    assign bus.scan_done       = done_q;
endmodule

// File: tb/tb_finder_pattern_scan.sv
// Directed bench for finder_pattern_scan on a 32x32 frame with a 2-cycle frame-buffer model.
module tb_finder_pattern_scan;
    localparam int unsigned W   = 32;
    localparam int unsigned H   = 32;
    localparam int unsigned RL  = 2;
    localparam int          LAT = 2 * W * H + 2 * (RL + 1);

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic img [W*H];
    logic rd1, rd2;
    logic [479:0] exp_h, exp_v, sq_v;
    int n_pass = 0;
    int n_chk  = 0;

    finder_pattern_scan_if bus();

    finder_pattern_scan #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(RL)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        rd1 <= img[10'(bus.address_reading)];
        rd2 <= rd1;
    end
    assign bus.pixel_reading = rd2;

    task automatic chk(input string tag, input logic [479:0] obs, input logic [479:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic fill_white();
        for (int i = 0; i < W * H; i++) img[i] = 1'b1;
    endtask

    task automatic rect(input int x0, input int y0, input int x1, input int y1, input logic v);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) img[y * W + x] = v;
    endtask

    task automatic hrun(input int y, input int x0, input int x1);
        rect(x0, y, x1, y, 1'b0);
    endtask

    task automatic square_at4();
        fill_white();
        rect(4, 4, 10, 10, 1'b0);
        rect(5, 5, 9, 9, 1'b1);
        rect(6, 6, 8, 8, 1'b0);
    endtask

    // One scan; optionally pokes start_scan or pulses reset at a given cycle offset
    task automatic run_scan(input string tag, input int poke_at, input int rst_at,
                            input logic [479:0] eh, input logic [479:0] ev);
        int cyc;
        @(negedge clk_in);
        bus.start_scan = 1'b1;
        @(negedge clk_in);
        bus.start_scan = 1'b0;
        chk({tag, ":busy_start"}, 480'(bus.busy), 480'(1));
        chk({tag, ":addr_start"}, 480'(bus.address_reading), 480'(0));
        cyc = 0;
        while (bus.scan_done !== 1'b1 && cyc < LAT + 100) begin
            @(negedge clk_in);
            cyc++;
            bus.start_scan = (cyc == poke_at);
            if (cyc == rst_at) begin
                chk({tag, ":horz_mid"}, bus.horz_patterns, eh);
                rst_in = 1'b1;
                #1;
                chk({tag, ":rst_addr"}, 480'(bus.address_reading), 480'(0));
                chk({tag, ":rst_busy"}, 480'(bus.busy), 480'(0));
                chk({tag, ":rst_done"}, 480'(bus.scan_done), 480'(0));
                chk({tag, ":rst_horz"}, bus.horz_patterns, 480'(0));
                chk({tag, ":rst_vert"}, bus.vert_patterns, 480'(0));
                @(negedge clk_in);
                rst_in = 1'b0;
                @(negedge clk_in);
                chk({tag, ":idle_busy"}, 480'(bus.busy), 480'(0));
                return;
            end
        end
        chk({tag, ":latency"}, 480'(cyc), 480'(LAT));
        chk({tag, ":busy_done"}, 480'(bus.busy), 480'(0));
        chk({tag, ":horz"}, bus.horz_patterns, eh);
        chk({tag, ":vert"}, bus.vert_patterns, ev);
        @(negedge clk_in);
        chk({tag, ":done_pulse"}, 480'(bus.scan_done), 480'(0));
        chk({tag, ":horz_hold"}, bus.horz_patterns, eh);
    endtask

    initial begin
        bus.start_scan = 1'b0;
        fill_white();
        repeat (3) @(negedge clk_in);
        chk("reset:addr", 480'(bus.address_reading), 480'(0));
        chk("reset:busy", 480'(bus.busy), 480'(0));
        chk("reset:done", 480'(bus.scan_done), 480'(0));
        chk("reset:horz", bus.horz_patterns, 480'(0));
        chk("reset:vert", bus.vert_patterns, 480'(0));
        rst_in = 1'b0;

        run_scan("white", -1, -1, 480'(0), 480'(0));

        // Row 10: B2 W2 B6 W2 B2 starting at x=5, centre 9+3
        fill_white();
        hrun(10, 5, 6);
        hrun(10, 9, 14);
        hrun(10, 17, 18);
        exp_h = '0;
        exp_h[12] = 1'b1;
        run_scan("row", -1, -1, exp_h, 480'(0));

        // 7x7 square at (4,4): 1:1:3:1:1 rows and columns 6..8, centre 7
        square_at4();
        sq_v = '0;
        sq_v[7] = 1'b1;
        run_scan("square", -1, -1, sq_v, sq_v);

        // Equal runs fail the core-width test
        fill_white();
        hrun(3, 0, 1);
        hrun(3, 4, 5);
        hrun(3, 8, 9);
        run_scan("reject", -1, -1, 480'(0), 480'(0));

        // Row 20 ends black at x=31, row 21 starts black at x=0; no merge across lines
        fill_white();
        hrun(20, 18, 19);
        hrun(20, 22, 27);
        hrun(20, 30, 31);
        hrun(21, 0, 1);
        hrun(21, 4, 9);
        hrun(21, 12, 13);
        exp_h = '0;
        exp_h[25] = 1'b1;
        exp_h[7]  = 1'b1;
        exp_v = '0;
        run_scan("edge", -1, -1, exp_h, exp_v);

        square_at4();
        run_scan("rst_mid", -1, 1500, sq_v, sq_v);
        run_scan("rescan", -1, -1, sq_v, sq_v);
        run_scan("poke", 100, -1, sq_v, sq_v);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
